// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings and helpers for the pipeline hazard controller.
// Tuse/Tnew codes, forward-select codes and mult/div latency defaults.
package hazard_ctrl_pkg;

    localparam logic [1:0] TUSE_NONE = 2'd3;
    localparam logic [1:0] TNEW_NOW  = 2'd0;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_W  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;

    localparam int MD_MUL_CYC_DEF = 5;
    localparam int MD_DIV_CYC_DEF = 10;
    localparam int CNT_W_DEF      = 32;

    // $0 is hardwired, so a write to it never produces a hazard.
    function automatic logic reg_match(input logic we, input logic [4:0] a3, input logic [4:0] r);
        return we && (a3 == r) && (r != 5'd0);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic m_hit, input logic w_hit);
        if (m_hit)
            return FWD_M;
        else if (w_hit)
            return FWD_W;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_ctr.sv
// Mult/div occupancy counter: loads the op latency on start, counts down to idle.
// md_busy is derived from the registered count, so it rises the cycle after start.
module md_busy_ctr
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_CYC = MD_MUL_CYC_DEF,
    parameter int DIV_CYC = MD_DIV_CYC_DEF
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_start,
    input  logic i_is_div,
    output logic o_busy
);

    localparam int MAX_CYC = (DIV_CYC > MUL_CYC) ? DIV_CYC : MUL_CYC;
    localparam int CTR_W   = $clog2(MAX_CYC + 1);

    logic [CTR_W-1:0] r_count;

    // A start while already busy simply restarts the count.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_count <= '0;
        else if (i_start)
            r_count <= i_is_div ? CTR_W'(DIV_CYC) : CTR_W'(MUL_CYC);
        else if (r_count != '0)
            r_count <= r_count - CTR_W'(1);
    end

    assign o_busy = (r_count != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forward control for the 5-stage pipeline, plus mult/div busy and stall counters.
// Stall and forward selects are combinational from the current stage contents.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MD_MUL_CYC = MD_MUL_CYC_DEF,
    parameter int MD_DIV_CYC = MD_DIV_CYC_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [4:0]       i_D_rs,
    input  logic [4:0]       i_D_rt,
    input  logic [1:0]       i_D_Tuse_rs,
    input  logic [1:0]       i_D_Tuse_rt,
    input  logic             i_D_md_op,
    input  logic [4:0]       i_E_rs,
    input  logic [4:0]       i_E_rt,
    input  logic [4:0]       i_E_A3,
    input  logic [1:0]       i_E_Tnew,
    input  logic             i_E_Reg_Write,
    input  logic [4:0]       i_M_rt,
    input  logic [4:0]       i_M_A3,
    input  logic [1:0]       i_M_Tnew,
    input  logic             i_M_Reg_Write,
    input  logic [4:0]       i_W_A3,
    input  logic             i_W_Reg_Write,
    input  logic             i_E_md_start,
    input  logic             i_E_md_is_div,
    output logic             o_PC_WE,
    output logic             o_F_D_WE,
    output logic             o_D_E_clear,
    output logic [1:0]       o_D_fwd_rs,
    output logic [1:0]       o_D_fwd_rt,
    output logic [1:0]       o_E_fwd_rs,
    output logic [1:0]       o_E_fwd_rt,
    output logic             o_M_fwd_rt,
    output logic             o_md_busy,
    output logic [CNT_W-1:0] o_stall_cnt
);

    logic w_stall_rs;
    logic w_stall_rt;
    logic w_stall_md;
    logic w_stall;
    logic w_m_ready;
    logic [CNT_W-1:0] r_stall_cnt;

    // A source stalls when its producer will not have the value before D needs it.
    assign w_stall_rs = (i_D_Tuse_rs != TUSE_NONE) &&
                        ((reg_match(i_E_Reg_Write, i_E_A3, i_D_rs) && (i_D_Tuse_rs < i_E_Tnew)) ||
                         (reg_match(i_M_Reg_Write, i_M_A3, i_D_rs) && (i_D_Tuse_rs < i_M_Tnew)));
    assign w_stall_rt = (i_D_Tuse_rt != TUSE_NONE) &&
                        ((reg_match(i_E_Reg_Write, i_E_A3, i_D_rt) && (i_D_Tuse_rt < i_E_Tnew)) ||
                         (reg_match(i_M_Reg_Write, i_M_A3, i_D_rt) && (i_D_Tuse_rt < i_M_Tnew)));
    assign w_stall_md = i_D_md_op && (o_md_busy || i_E_md_start);
    assign w_stall    = w_stall_rs | w_stall_rt | w_stall_md;

    assign o_PC_WE     = ~w_stall;
    assign o_F_D_WE    = ~w_stall;
    assign o_D_E_clear = w_stall;

    // M can only forward once its result exists; W's result always does.
    assign w_m_ready = (i_M_Tnew == TNEW_NOW);

    assign o_D_fwd_rs = fwd_sel(reg_match(i_M_Reg_Write, i_M_A3, i_D_rs) && w_m_ready,
                                reg_match(i_W_Reg_Write, i_W_A3, i_D_rs));
    assign o_D_fwd_rt = fwd_sel(reg_match(i_M_Reg_Write, i_M_A3, i_D_rt) && w_m_ready,
                                reg_match(i_W_Reg_Write, i_W_A3, i_D_rt));
    assign o_E_fwd_rs = fwd_sel(reg_match(i_M_Reg_Write, i_M_A3, i_E_rs) && w_m_ready,
                                reg_match(i_W_Reg_Write, i_W_A3, i_E_rs));
    assign o_E_fwd_rt = fwd_sel(reg_match(i_M_Reg_Write, i_M_A3, i_E_rt) && w_m_ready,
                                reg_match(i_W_Reg_Write, i_W_A3, i_E_rt));
    assign o_M_fwd_rt = reg_match(i_W_Reg_Write, i_W_A3, i_M_rt);

    md_busy_ctr #(
        .MUL_CYC (MD_MUL_CYC),
        .DIV_CYC (MD_DIV_CYC)
    ) u_md_busy_ctr (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_start  (i_E_md_start),
        .i_is_div (i_E_md_is_div),
        .o_busy   (o_md_busy)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_stall_cnt <= '0;
        else if (w_stall)
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end

    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level reference model.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  D_rs, D_rt, E_rs, E_rt, E_A3, M_rt, M_A3, W_A3;
    logic [1:0]  D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
    logic        D_md_op, E_RW, M_RW, W_RW, E_md_start, E_md_is_div;
    logic        PC_WE, F_D_WE, D_E_clear, M_fwd_rt, md_busy;
    logic [1:0]  D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt;
    logic [31:0] stall_cnt;

    int          passed = 0;
    int          total  = 0;
    int          m_busy_left;
    int unsigned m_stall;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .i_clk(clk), .i_reset(rst),
        .i_D_rs(D_rs), .i_D_rt(D_rt), .i_D_Tuse_rs(D_Tuse_rs), .i_D_Tuse_rt(D_Tuse_rt),
        .i_D_md_op(D_md_op), .i_E_rs(E_rs), .i_E_rt(E_rt), .i_E_A3(E_A3),
        .i_E_Tnew(E_Tnew), .i_E_Reg_Write(E_RW), .i_M_rt(M_rt), .i_M_A3(M_A3),
        .i_M_Tnew(M_Tnew), .i_M_Reg_Write(M_RW), .i_W_A3(W_A3), .i_W_Reg_Write(W_RW),
        .i_E_md_start(E_md_start), .i_E_md_is_div(E_md_is_div),
        .o_PC_WE(PC_WE), .o_F_D_WE(F_D_WE), .o_D_E_clear(D_E_clear),
        .o_D_fwd_rs(D_fwd_rs), .o_D_fwd_rt(D_fwd_rt), .o_E_fwd_rs(E_fwd_rs),
        .o_E_fwd_rt(E_fwd_rt), .o_M_fwd_rt(M_fwd_rt), .o_md_busy(md_busy),
        .o_stall_cnt(stall_cnt)
    );

    // ---------------- reference model ----------------
    function automatic bit writes(input bit we, input int a3, input int r);
        return we && (a3 == r) && (r != 0);
    endfunction

    function automatic bit src_stall(input int r, input int tuse);
        if (tuse == 3) return 1'b0;
        if (writes(E_RW, E_A3, r) && tuse < int'(E_Tnew)) return 1'b1;
        if (writes(M_RW, M_A3, r) && tuse < int'(M_Tnew)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [1:0] src_fwd(input int r);
        if (writes(M_RW, M_A3, r) && M_Tnew == 2'd0) return 2'd2;
        if (writes(W_RW, W_A3, r)) return 2'd1;
        return 2'd0;
    endfunction

    function automatic bit model_stall();
        bit md_hold;
        md_hold = D_md_op && (m_busy_left > 0 || E_md_start);
        return src_stall(D_rs, D_Tuse_rs) || src_stall(D_rt, D_Tuse_rt) || md_hold;
    endfunction

    function automatic logic [12:0] model_comb();
        bit s;
        s = model_stall();
        return {~s, ~s, s, src_fwd(D_rs), src_fwd(D_rt), src_fwd(E_rs), src_fwd(E_rt),
                writes(W_RW, W_A3, M_rt)};
    endfunction

    function automatic logic [12:0] dut_comb();
        return {PC_WE, F_D_WE, D_E_clear, D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt, M_fwd_rt};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic clear_inputs();
        D_rs = 0; D_rt = 0; E_rs = 0; E_rt = 0; E_A3 = 0; M_rt = 0; M_A3 = 0; W_A3 = 0;
        D_Tuse_rs = 2'd3; D_Tuse_rt = 2'd3; E_Tnew = 0; M_Tnew = 0;
        D_md_op = 0; E_RW = 0; M_RW = 0; W_RW = 0; E_md_start = 0; E_md_is_div = 0;
    endtask

    // One clock: advance the model with the inputs present before the edge.
    task automatic step();
        bit s;
        s = model_stall();
        @(posedge clk);
        if (s) m_stall = m_stall + 1;
        if (E_md_start) m_busy_left = E_md_is_div ? 10 : 5;
        else if (m_busy_left > 0) m_busy_left = m_busy_left - 1;
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        m_busy_left = 0;
        m_stall = 0;
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        clear_inputs();
        D_Tuse_rs = 0; D_Tuse_rt = 0;
        #1;
        total++; if (dut_comb() !== 13'b1_1_0_00_00_00_00_0)
            $display("FAIL reset_comb: got %b want %b", dut_comb(), 13'b1_1_0_00_00_00_00_0); else passed++;
        total++; if (md_busy !== 1'b0) $display("FAIL reset_md_busy: got %b want 0", md_busy); else passed++;
        total++; if (stall_cnt !== 32'd0) $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); else passed++;
        step();
    endtask

    task automatic test_lw_use();
        clear_inputs();
        E_A3 = 5; E_Tnew = 2; E_RW = 1; D_rs = 5; D_Tuse_rs = 0;
        #1;
        total++; if ({PC_WE, F_D_WE, D_E_clear} !== 3'b001)
            $display("FAIL lw_use_stall: got %b want 001", {PC_WE, F_D_WE, D_E_clear}); else passed++;
        D_Tuse_rs = 2;
        #1;
        total++; if ({PC_WE, F_D_WE, D_E_clear} !== 3'b110)
            $display("FAIL tuse_eq_tnew: got %b want 110", {PC_WE, F_D_WE, D_E_clear}); else passed++;
        D_Tuse_rs = 3;
        #1;
        total++; if (D_E_clear !== 1'b0) $display("FAIL tuse_none: got %b want 0", D_E_clear); else passed++;
        E_A3 = 0; E_Tnew = 0; D_Tuse_rt = 1; D_rt = 9; M_A3 = 9; M_Tnew = 2; M_RW = 1;
        #1;
        total++; if (D_E_clear !== 1'b1) $display("FAIL m_stage_stall: got %b want 1", D_E_clear); else passed++;
        step();
    endtask

    task automatic test_zero_reg();
        clear_inputs();
        E_A3 = 0; E_Tnew = 2; E_RW = 1; D_rs = 0; D_Tuse_rs = 0;
        #1;
        total++; if ({D_E_clear, D_fwd_rs} !== 3'b000)
            $display("FAIL zero_no_stall: got %b want 000", {D_E_clear, D_fwd_rs}); else passed++;
        E_RW = 0; M_A3 = 0; M_Tnew = 0; M_RW = 1; W_A3 = 0; W_RW = 1;
        #1;
        total++; if ({D_fwd_rs, E_fwd_rs, M_fwd_rt} !== 5'b0)
            $display("FAIL zero_no_fwd: got %b want 00000", {D_fwd_rs, E_fwd_rs, M_fwd_rt}); else passed++;
        step();
    endtask

    task automatic test_priority();
        clear_inputs();
        D_rt = 7; D_Tuse_rt = 1; E_rs = 7; M_rt = 7;
        M_A3 = 7; M_Tnew = 0; M_RW = 1; W_A3 = 7; W_RW = 1;
        #1;
        total++; if ({D_fwd_rt, E_fwd_rs} !== 4'b1010)
            $display("FAIL prio_m_over_w: got %b want 1010", {D_fwd_rt, E_fwd_rs}); else passed++;
        total++; if (M_fwd_rt !== 1'b1) $display("FAIL m_fwd_from_w: got %b want 1", M_fwd_rt); else passed++;
        M_RW = 0;
        #1;
        total++; if ({D_fwd_rt, E_fwd_rs} !== 4'b0101)
            $display("FAIL prio_w_only: got %b want 0101", {D_fwd_rt, E_fwd_rs}); else passed++;
        M_RW = 1; M_Tnew = 1;
        #1;
        total++; if (E_fwd_rs !== 2'd1) $display("FAIL m_not_ready: got %0d want 1", E_fwd_rs); else passed++;
        step();
    endtask

    task automatic test_mult();
        int stalls = 0;
        int busy = 0;
        do_reset();
        clear_inputs();
        D_md_op = 1; E_md_start = 1; E_md_is_div = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (PC_WE === 1'b0) stalls++;
            if (md_busy === 1'b1) busy++;
            total++; if (md_busy !== (m_busy_left != 0))
                $display("FAIL mult_busy_cyc%0d: got %b want %b", i, md_busy, m_busy_left != 0); else passed++;
            step();
            E_md_start = 0;
        end
        total++; if (busy != 5) $display("FAIL mult_busy_len: got %0d want 5", busy); else passed++;
        total++; if (stalls != 6) $display("FAIL mult_stall_len: got %0d want 6", stalls); else passed++;
        #1;
        total++; if (stall_cnt !== 32'd6) $display("FAIL mult_stall_cnt: got %0d want 6", stall_cnt); else passed++;
    endtask

    task automatic test_div_reset();
        do_reset();
        clear_inputs();
        D_md_op = 1; E_md_start = 1; E_md_is_div = 1;
        step();
        E_md_start = 0;
        step(); step(); step();
        #1;
        total++; if ({md_busy, stall_cnt} !== {1'b1, 32'd4})
            $display("FAIL div_pre_reset: got busy=%b cnt=%0d want busy=1 cnt=4", md_busy, stall_cnt); else passed++;
        rst = 1'b1;
        m_busy_left = 0; m_stall = 0;
        #1;
        total++; if ({md_busy, stall_cnt} !== {1'b0, 32'd0})
            $display("FAIL div_async_reset: got busy=%b cnt=%0d want 0/0", md_busy, stall_cnt); else passed++;
        total++; if (PC_WE !== 1'b1) $display("FAIL reset_comb_follow: got %b want 1", PC_WE); else passed++;
        do_reset();
    endtask

    task automatic test_stall_cnt();
        do_reset();
        clear_inputs();
        E_A3 = 5; E_Tnew = 2; E_RW = 1; D_rs = 5; D_Tuse_rs = 0;
        step(); step(); step();
        clear_inputs();
        D_md_op = 1; E_md_start = 1;
        step();
        E_md_start = 0;
        step();
        D_md_op = 0;
        step(); step();
        #1;
        total++; if (stall_cnt !== 32'd5) $display("FAIL stall_cnt_5: got %0d want 5", stall_cnt); else passed++;
        step(); step();
        #1;
        total++; if (stall_cnt !== 32'd5) $display("FAIL stall_cnt_hold: got %0d want 5", stall_cnt); else passed++;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            D_rs = 5'($urandom_range(0, 3)); D_rt = 5'($urandom_range(0, 3));
            E_rs = 5'($urandom_range(0, 3)); E_rt = 5'($urandom_range(0, 3));
            E_A3 = 5'($urandom_range(0, 3)); M_A3 = 5'($urandom_range(0, 3));
            W_A3 = 5'($urandom_range(0, 3)); M_rt = 5'($urandom_range(0, 3));
            D_Tuse_rs = 2'($urandom_range(0, 3)); D_Tuse_rt = 2'($urandom_range(0, 3));
            E_Tnew = 2'($urandom_range(0, 2)); M_Tnew = 2'($urandom_range(0, 1));
            E_RW = 1'($urandom); M_RW = 1'($urandom); W_RW = 1'($urandom);
            D_md_op = ($urandom_range(0, 3) == 0);
            E_md_start = ($urandom_range(0, 11) == 0);
            E_md_is_div = 1'($urandom);
            #1;
            total++; if (dut_comb() !== model_comb())
                $display("FAIL rand_comb_%0d: got %b want %b", i, dut_comb(), model_comb()); else passed++;
            total++; if (md_busy !== (m_busy_left != 0))
                $display("FAIL rand_busy_%0d: got %b want %b", i, md_busy, m_busy_left != 0); else passed++;
            total++; if (stall_cnt !== m_stall)
                $display("FAIL rand_cnt_%0d: got %0d want %0d", i, stall_cnt, m_stall); else passed++;
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        m_busy_left = 0;
        m_stall = 0;
        test_reset();
        test_lw_use();
        test_zero_reg();
        test_priority();
        test_mult();
        test_div_reset();
        test_stall_cnt();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
